easy_cpu_core: RTL and testbench

//  Parametrised multi-cycle successor to the 16x32 easy CPU core: same 32-bit instruction format and ALU set.

---
 rtl/easy_cpu_core_if.sv | 54 +++++
 rtl/easy_cpu_core.sv | 174 +++++++++++++++++
 tb/tb_easy_cpu_core.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/easy_cpu_core_if.sv
// easy_cpu_core_if: bus bundle between the easy CPU core and its environment.
//   code_addr  : PC, word address of the instruction being fetched (core -> ROM)
//   code_valid : code_data valid for code_addr this cycle, 0 = stall (ROM -> core)
//   code_data  : 32-bit instruction word (ROM -> core)
//   mem_req    : data access request, held until mem_ack (core -> RAM)
//   mem_we     : 1 = write, 0 = read, valid while mem_req (core -> RAM)
//   mem_addr   : data access address (core -> RAM)
//   mem_wdata  : write data (core -> RAM)
//   mem_ack    : access done, read data valid this cycle (RAM -> core)
//   mem_rdata  : read data (RAM -> core)
//   halted     : core stopped by HALT (core -> system)
// Modports: master = core side, slave = ROM/RAM/system side.
interface easy_cpu_core_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned PC_W = 16,
   parameter int unsigned AW   = 32
);
   logic [PC_W-1:0] code_addr;
   logic            code_valid;
   logic [31:0]     code_data;
   logic            mem_req;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_ack;
   logic [XLEN-1:0] mem_rdata;
   logic            halted;

   modport master (
      output code_addr,
      input  code_valid,
      input  code_data,
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata,
      output halted
   );

   modport slave (
      input  code_addr,
      output code_valid,
      output code_data,
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata,
      input  halted
   );
endinterface

// File: rtl/easy_cpu_core.sv
// easy_cpu_core: multi-cycle easy CPU core with stallable instruction fetch, req/ack data
// memory with arbitrary wait states, register jump and HALT.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : easy_cpu_core_if.master (code fetch, data memory handshake, halted flag)
// Parameters: XLEN (>=32, multiple of 16), NREG (power of 2, 2..16), PC_W, AW.
// Optional feature: define EASY_CPU_MUL_EN to enable ALU fn12 (multiply, low XLEN bits).
module easy_cpu_core #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 16,
   parameter int unsigned PC_W = 16,
   parameter int unsigned AW   = 32
) (
   input logic             clk,
   input logic             rst,
   easy_cpu_core_if.master bus
);
   localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int unsigned SW = $clog2(XLEN);
   localparam logic [XLEN-1:0] XLEN_VAL = XLEN'(XLEN);

   typedef enum logic [1:0] {StRun, StMem, StHalt} state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [XLEN-1:0] rf_q [NREG];
   logic [RW-1:0]   dest_q, dest_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            halted_q, halted_d;

   logic            rf_we;
   logic [RW-1:0]   rf_widx;
   logic [XLEN-1:0] rf_wdata;

   // Instruction fields; register indices take the low bits (index mod NREG).
   logic [2:0]      op;
   logic [4:0]      fn;
   logic [RW-1:0]   rd, ra, rb;
   logic [15:0]     imm;
   logic [XLEN-1:0] rd_val, ra_val, rb_val;
   logic [XLEN-1:0] alu_res;
   logic            alu_wr;
   logic            unused_bits;

   assign op     = bus.code_data[31:29];
   assign fn     = bus.code_data[28:24];
   assign rd     = bus.code_data[20 +: RW];
   assign ra     = bus.code_data[16 +: RW];
   assign rb     = bus.code_data[12 +: RW];
   assign imm    = bus.code_data[19:4];
   assign rd_val = rf_q[rd];
   assign ra_val = rf_q[ra];
   assign rb_val = rf_q[rb];
   assign unused_bits = ^bus.code_data[3:0];

   always_comb begin
      alu_res = rd_val;
      alu_wr  = 1'b1;
      case (fn)
         5'd0:  alu_res[15:0]  = imm;
         5'd1:  alu_res[31:16] = imm;
         5'd2:  alu_res = ra_val + rb_val;
         5'd3:  alu_res = ra_val - rb_val;
         5'd4:  alu_res = ra_val | rb_val;
         5'd5:  alu_res = ra_val & rb_val;
         5'd6:  alu_res = ~ra_val;
         // Full-width amount compare so huge shift counts give 0 rather than wrapping.
         5'd7:  alu_res = (rb_val >= XLEN_VAL) ? '0 : (ra_val << rb_val[SW-1:0]);
         5'd8:  alu_res = (rb_val >= XLEN_VAL) ? '0 : (ra_val >> rb_val[SW-1:0]);
         5'd9:  alu_res = {{(XLEN-1){1'b0}}, (ra_val > rb_val)};
         5'd10: alu_res = {{(XLEN-1){1'b0}}, (ra_val < rb_val)};
         5'd11: alu_res = {{(XLEN-1){1'b0}}, ($signed(ra_val) < $signed(rb_val))};
`ifdef EASY_CPU_MUL_EN
         5'd12: alu_res = ra_val * rb_val;
`endif
         default: alu_wr = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      dest_d   = dest_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      halted_d = halted_q;
      rf_we    = 1'b0;
      rf_widx  = rd;
      rf_wdata = alu_res;
      case (state_q)
         StRun: begin
            if (bus.code_valid) begin
               pc_d = pc_q + 1'b1;
               case (op)
                  3'd0: if (rd_val != '0) pc_d = pc_q + PC_W'(2);
                  3'd1: rf_we = alu_wr;
                  3'd2: begin
                     addr_d  = AW'(rd_val);
                     we_d    = 1'b0;
                     req_d   = 1'b1;
                     dest_d  = ra;
                     state_d = StMem;
                  end
                  3'd3: begin
                     addr_d  = AW'(rd_val);
                     wdata_d = ra_val;
                     we_d    = 1'b1;
                     req_d   = 1'b1;
                     state_d = StMem;
                  end
                  3'd4: pc_d = PC_W'(rd_val);
                  3'd7: begin
                     pc_d     = pc_q;
                     halted_d = 1'b1;
                     state_d  = StHalt;
                  end
                  default: ;
               endcase
            end
         end
         StMem: begin
            // Request fields stay untouched until the ack; code_valid is not looked at here.
            if (bus.mem_ack) begin
               if (!we_q) begin
                  rf_we    = 1'b1;
                  rf_widx  = dest_q;
                  rf_wdata = bus.mem_rdata;
               end
               req_d   = 1'b0;
               state_d = StRun;
            end
         end
         StHalt: ;
         default: state_d = StHalt;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StRun;
         pc_q     <= '0;
         dest_q   <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         halted_q <= 1'b0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         dest_q   <= dest_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         halted_q <= halted_d;
         if (rf_we) rf_q[rf_widx] <= rf_wdata;
      end
   end

   assign bus.code_addr = pc_q;
   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.halted    = halted_q;
endmodule

// File: tb/tb_easy_cpu_core.sv
// tb_easy_cpu_core: directed, table-driven bench for easy_cpu_core (default parameters).
// Register contents are observed by storing them through the data-memory port.
module tb_easy_cpu_core;
   localparam logic [31:0] HALT_W = 32'hE000_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] pc_exp;
   logic [31:0] mem_model [logic [31:0]];

   easy_cpu_core_if #(.XLEN(32), .PC_W(16), .AW(32)) bus ();

   easy_cpu_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      bit          abs_pc;
      logic [15:0] pc_val;
      int          reg_idx;
      logic [31:0] reg_val;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic [31:0] instr, input bit abs_pc, input logic [15:0] pc_val,
                              input int reg_idx, input logic [31:0] reg_val);
      vec_t r;
      r.instr = instr; r.abs_pc = abs_pc; r.pc_val = pc_val;
      r.reg_idx = reg_idx; r.reg_val = reg_val;
      return r;
   endfunction

   function automatic logic [31:0] alu(input int fn, input int rd, input int ra, input int rb);
      logic [31:0] w;
      w = '0;
      w[31:29] = 3'd1; w[28:24] = fn[4:0]; w[23:20] = rd[3:0];
      w[19:16] = ra[3:0]; w[15:12] = rb[3:0];
      return w;
   endfunction

   function automatic logic [31:0] ldi(input int fn, input int rd, input logic [15:0] imm);
      logic [31:0] w;
      w = '0;
      w[31:29] = 3'd1; w[28:24] = fn[4:0]; w[23:20] = rd[3:0]; w[19:4] = imm;
      return w;
   endfunction

   function automatic logic [31:0] ins(input int op, input int rd, input int ra);
      logic [31:0] w;
      w = '0;
      w[31:29] = op[2:0]; w[23:20] = rd[3:0]; w[19:16] = ra[3:0];
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Present one instruction for one clock; returns at posedge+1.
   task automatic exec(input logic [31:0] instr);
      bus.code_valid = 1'b1;
      bus.code_data  = instr;
      @(posedge clk); #1;
      bus.code_valid = 1'b0;
      bus.code_data  = '0;
   endtask

   // Serve an outstanding access after `delay` wait cycles; entry right after the issue edge.
   task automatic run_mem(input int delay, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit chk_wdata, input string tag);
      int          hi;
      logic [31:0] rdata;
      hi    = 0;
      rdata = mem_model.exists(addr) ? mem_model[addr] : 32'h0;
      // A HALT word offered during the access must be ignored.
      bus.code_valid = 1'b1;
      bus.code_data  = HALT_W;
      for (int i = 0; i <= delay; i++) begin
         if (bus.mem_req === 1'b1) hi++;
         check({tag, "_we"}, 32'(bus.mem_we), 32'(we));
         check({tag, "_addr"}, bus.mem_addr, addr);
         if (chk_wdata) check({tag, "_wdata"}, bus.mem_wdata, wdata);
         if (i == delay) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdata;
         end
         @(posedge clk); #1;
      end
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = '0;
      bus.code_valid = 1'b0;
      bus.code_data  = '0;
      if (we) mem_model[addr] = wdata;
      check({tag, "_req_cycles"}, 32'(hi), 32'(delay + 1));
      check({tag, "_req_drop"}, 32'(bus.mem_req), 32'd0);
      check({tag, "_not_halted"}, 32'(bus.halted), 32'd0);
   endtask

   // Read a register out via ST [r0] <= r[idx] (r0 is never written and stays 0).
   task automatic check_reg(input int idx, input logic [31:0] exp, input string tag);
      exec(ins(3, 0, idx));
      pc_exp = pc_exp + 16'd1;
      run_mem(0, 1'b1, 32'h0, exp, 1'b1, tag);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pc"}, 32'(bus.code_addr), 32'h0);
      check({tag, "_req"}, 32'(bus.mem_req), 32'h0);
      check({tag, "_we"}, 32'(bus.mem_we), 32'h0);
      check({tag, "_addr"}, bus.mem_addr, 32'h0);
      check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
      check({tag, "_halted"}, 32'(bus.halted), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] mul_exp;
`ifdef EASY_CPU_MUL_EN
      mul_exp = 32'd21;
`else
      mul_exp = 32'd0;
`endif
      bus.code_valid = 1'b0;
      bus.code_data  = '0;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = '0;

      vecs.push_back(v(ldi(0, 1, 16'h0005), 0, 1, -1, 0));
      vecs.push_back(v(ldi(1, 1, 16'h0001), 0, 1, 1, 32'h0001_0005));
      vecs.push_back(v(ldi(0, 2, 16'h0003), 0, 1, 2, 32'd3));
      vecs.push_back(v(alu(2, 3, 1, 2), 0, 1, 3, 32'h0001_0008));
      vecs.push_back(v(ins(0, 3, 0), 0, 2, -1, 0));            // BNZ taken
      vecs.push_back(v(ins(0, 4, 0), 0, 1, -1, 0));            // BNZ r4=0
      vecs.push_back(v(ldi(0, 7, 16'h0001), 0, 1, 7, 32'd1));
      vecs.push_back(v(alu(3, 6, 4, 7), 0, 1, 6, 32'hFFFF_FFFF));
      vecs.push_back(v(ldi(0, 8, 16'd40), 0, 1, -1, 0));
      vecs.push_back(v(alu(7, 9, 2, 8), 0, 1, 9, 32'h0));      // shl by 40
      vecs.push_back(v(alu(7, 9, 2, 7), 0, 1, 9, 32'd6));
      vecs.push_back(v(alu(8, 10, 6, 7), 0, 1, 10, 32'h7FFF_FFFF));
      vecs.push_back(v(alu(8, 10, 6, 8), 0, 1, 10, 32'h0));    // shr by 40
      vecs.push_back(v(alu(11, 11, 6, 7), 0, 1, 11, 32'd1));   // signed -1 < 1
      vecs.push_back(v(alu(10, 12, 6, 7), 0, 1, 12, 32'd0));   // unsigned lt
      vecs.push_back(v(alu(9, 13, 6, 7), 0, 1, 13, 32'd1));    // unsigned gt
      vecs.push_back(v(alu(4, 14, 1, 2), 0, 1, 14, 32'h0001_0007));
      vecs.push_back(v(alu(5, 14, 1, 3), 0, 1, 14, 32'h0001_0000));
      vecs.push_back(v(ldi(0, 3, 16'h1234), 0, 1, 3, 32'h0001_1234));
      vecs.push_back(v(alu(6, 14, 2, 0), 0, 1, 14, 32'hFFFF_FFFC));
      vecs.push_back(v(alu(20, 14, 1, 2), 0, 1, 14, 32'hFFFF_FFFC)); // unlisted fn
      vecs.push_back(v(ins(5, 14, 1), 0, 1, 14, 32'hFFFF_FFFC));     // op5
      vecs.push_back(v(ldi(0, 7, 16'h0007), 0, 1, -1, 0));
      vecs.push_back(v(alu(12, 15, 2, 7), 0, 1, 15, mul_exp));
      vecs.push_back(v(alu(2, 2, 2, 2), 0, 1, 2, 32'd6));       // rd == ra
      vecs.push_back(v(ldi(0, 4, 16'h0100), 0, 1, -1, 0));
      vecs.push_back(v(ins(4, 4, 0), 1, 16'h0100, -1, 0));      // JR
      vecs.push_back(v(ldi(0, 4, 16'hFFFF), 0, 1, -1, 0));
      vecs.push_back(v(ins(4, 4, 0), 1, 16'hFFFF, -1, 0));
      vecs.push_back(v(ins(6, 0, 0), 1, 16'h0000, -1, 0));      // pc wrap

      // Reset
      #12;
      check_reset_state("reset");
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      pc_exp = 16'h0;

      foreach (vecs[i]) begin
         exec(vecs[i].instr);
         pc_exp = vecs[i].abs_pc ? vecs[i].pc_val : pc_exp + vecs[i].pc_val;
         check($sformatf("vec%0d_pc", i), 32'(bus.code_addr), 32'(pc_exp));
         if (vecs[i].reg_idx >= 0)
            check_reg(vecs[i].reg_idx, vecs[i].reg_val, $sformatf("vec%0d_r%0d", i, vecs[i].reg_idx));
      end

      // Store then load with three wait states each
      exec(ldi(0, 2, 16'h0003));
      pc_exp = pc_exp + 16'd1;
      exec(ins(3, 1, 2));
      pc_exp = pc_exp + 16'd1;
      check("st_issue_pc", 32'(bus.code_addr), 32'(pc_exp));
      run_mem(3, 1'b1, 32'h0001_0005, 32'd3, 1'b1, "st");
      exec(ins(2, 1, 5));
      pc_exp = pc_exp + 16'd1;
      run_mem(3, 1'b0, 32'h0001_0005, 32'h0, 1'b0, "ld");
      check("ld_pc", 32'(bus.code_addr), 32'(pc_exp));
      check_reg(5, 32'd3, "ld_r5");

      // Fetch stall: garbage words with code_valid low must change nothing
      for (int i = 0; i < 5; i++) begin
         bus.code_data = (i % 2 == 0) ? HALT_W : ldi(0, 5, 16'hFFFF);
         @(posedge clk); #1;
         check($sformatf("stall%0d_pc", i), 32'(bus.code_addr), 32'(pc_exp));
      end
      bus.code_data = '0;
      check("stall_halted", 32'(bus.halted), 32'h0);
      exec(alu(2, 3, 1, 2));
      pc_exp = pc_exp + 16'd1;
      check_reg(3, 32'h0001_0008, "stall_resume_r3");
      check_reg(5, 32'd3, "stall_r5");

      // mem_ack without a request is ignored
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
      repeat (2) begin @(posedge clk); #1; end
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      check("stray_ack_req", 32'(bus.mem_req), 32'h0);
      check("stray_ack_pc", 32'(bus.code_addr), 32'(pc_exp));
      check_reg(5, 32'd3, "stray_ack_r5");

      // HALT is absorbing
      exec(HALT_W);
      check("halt_flag", 32'(bus.halted), 32'h1);
      check("halt_pc", 32'(bus.code_addr), 32'(pc_exp));
      bus.code_valid = 1'b1;
      bus.code_data  = ins(3, 1, 2);
      repeat (3) begin @(posedge clk); #1; end
      bus.code_valid = 1'b0;
      bus.code_data  = '0;
      check("halt_hold_pc", 32'(bus.code_addr), 32'(pc_exp));
      check("halt_hold_flag", 32'(bus.halted), 32'h1);
      check("halt_hold_req", 32'(bus.mem_req), 32'h0);

      // Reset clears HALT; then reset in the middle of a load
      rst = 1'b0;
      #2;
      check_reset_state("rst_halt");
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      pc_exp = 16'h0;
      exec(ldi(0, 1, 16'h0040));
      exec(ins(2, 1, 5));
      check("rst_mem_req_before", 32'(bus.mem_req), 32'h1);
      #2 rst = 1'b0;
      #1;
      check("rst_mem_req_drop", 32'(bus.mem_req), 32'h0);
      check("rst_mem_pc", 32'(bus.code_addr), 32'h0);
      @(negedge clk) rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      check("rst_mem_abandon", 32'(bus.mem_req), 32'h0);
      check_reg(1, 32'h0, "rst_r1");
      check_reg(5, 32'h0, "rst_r5");
      check("rst_final_pc", 32'(bus.code_addr), 32'(pc_exp));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
